// File: rtl/mole_field_pkg.sv
// mole_field_pkg: shared game constants and hole-code type for the mole engine
package mole_field_pkg;
  localparam int GAME_LOC_W = 4;
  localparam int GAME_NUM_HOLES = 9;
  localparam logic [GAME_LOC_W-1:0] GAME_EMPTY = '1;
  typedef logic [GAME_LOC_W-1:0] hole_t;
endpackage

// File: rtl/mole_slot.sv
// mole_slot: one mole slot holding a hole code and its life counter
module mole_slot
  import mole_field_pkg::*;
#(
  parameter int LOC_W = GAME_LOC_W,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             spawn,
  input  logic [LOC_W-1:0] loc,
  input  logic             kill,
  input  logic [CNT_W-1:0] life_span,
  output logic [LOC_W-1:0] code,
  output logic             hit,
  output logic             expire
);
  localparam logic [LOC_W-1:0] EMPTY = '1;
  logic [LOC_W-1:0] code_q, code_d;
  logic [CNT_W-1:0] life_q, life_d;
  logic             occ;
  // kill beats expiry; spawn only lands on a vacant slot
  always_comb begin
    occ    = code_q != EMPTY;
    hit    = enable && occ && kill;
    expire = enable && occ && !kill && (life_q == life_span);
    code_d = code_q;
    life_d = life_q;
    if (enable) begin
      if (spawn && !occ) begin
        code_d = loc;
        life_d = '0;
      end else if (hit || expire) begin
        code_d = EMPTY;
        life_d = '0;
      end else begin
        life_d = occ ? life_q + CNT_W'(1) : '0;
      end
    end
  end
  // slot state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= EMPTY;
      life_q <= '0;
    end else begin
      code_q <= code_d;
      life_q <= life_d;
    end
  end
  assign code = code_q;
endmodule

// File: rtl/mole_field.sv
// mole_field: mole population engine - spawning, expiry, kills and statistics
module mole_field
  import mole_field_pkg::*;
#(
  parameter int NUM_SLOTS = 5,
  parameter int NUM_HOLES = GAME_NUM_HOLES,
  parameter int LOC_W     = GAME_LOC_W,
  parameter int CNT_W     = 32,
  parameter int STAT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [CNT_W-1:0]           life_span,
  input  logic [CNT_W-1:0]           gen_interval,
  input  logic [NUM_SLOTS-1:0]       kill_list,
  input  logic [31:0]                rand_in,
  output logic [NUM_SLOTS*LOC_W-1:0] moles,
  output logic                       hit_pulse,
  output logic                       escape_pulse,
  output logic                       spawn_pulse,
  output logic [STAT_W-1:0]          hit_count,
  output logic [STAT_W-1:0]          escape_count
);
  localparam logic [LOC_W-1:0] EMPTY = '1;
  localparam int SW = STAT_W + 8;
  localparam logic [SW-1:0] STAT_MAX = {8'd0, {STAT_W{1'b1}}};
  logic [CNT_W-1:0]     ic_q, ic_d;
  logic                 attempt;
  logic [NUM_SLOTS-1:0] spawn_v, hit_v, exp_v;
  logic [LOC_W-1:0]     code [NUM_SLOTS];
  logic [NUM_HOLES-1:0] held;
  logic [31:0]          l0;
  logic                 found_hi;
  logic [LOC_W-1:0]     loc, loc_hi, loc_any;
  logic [SW-1:0]        hit_sum, esc_sum;
  logic                 hit_pulse_q, hit_pulse_d, escape_pulse_q, escape_pulse_d;
  logic                 spawn_pulse_q, spawn_pulse_d;
  logic [STAT_W-1:0]    hit_count_q, hit_count_d, escape_count_q, escape_count_d;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    mole_slot #(.LOC_W(LOC_W), .CNT_W(CNT_W)) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .spawn    (spawn_v[i]),
      .loc      (loc),
      .kill     (kill_list[i]),
      .life_span(life_span),
      .code     (code[i]),
      .hit      (hit_v[i]),
      .expire   (exp_v[i])
    );
    assign moles[i*LOC_W +: LOC_W] = code[i];
  end

  // interval counter and lowest-index free slot selection
  always_comb begin
    attempt = enable && (ic_q == gen_interval);
    ic_d    = !enable ? ic_q : attempt ? '0 : ic_q + CNT_W'(1);
    spawn_v = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (attempt && code[i] == EMPTY) begin
        spawn_v    = '0;
        spawn_v[i] = 1'b1;
      end
    end
  end

  // probe from rand_in % NUM_HOLES upward with wrap; lowest unheld code at or above
  // the start wins, else the lowest unheld code overall
  always_comb begin
    held = '0;
    for (int h = 0; h < NUM_HOLES; h++)
      for (int i = 0; i < NUM_SLOTS; i++)
        if (code[i] == LOC_W'(h)) held[h] = 1'b1;
    l0       = rand_in % 32'(NUM_HOLES);
    found_hi = 1'b0;
    loc_hi   = '0;
    loc_any  = '0;
    for (int h = NUM_HOLES - 1; h >= 0; h--) begin
      if (!held[h]) begin
        loc_any = LOC_W'(h);
        if (32'(h) >= l0) begin
          loc_hi   = LOC_W'(h);
          found_hi = 1'b1;
        end
      end
    end
    loc = found_hi ? loc_hi : loc_any;
  end

  // event pulses and saturating statistics
  always_comb begin
    hit_sum = {8'd0, hit_count_q};
    esc_sum = {8'd0, escape_count_q};
    for (int i = 0; i < NUM_SLOTS; i++) begin
      hit_sum = hit_sum + SW'(hit_v[i]);
      esc_sum = esc_sum + SW'(exp_v[i]);
    end
    hit_count_d    = (hit_sum > STAT_MAX) ? '1 : hit_sum[STAT_W-1:0];
    escape_count_d = (esc_sum > STAT_MAX) ? '1 : esc_sum[STAT_W-1:0];
    hit_pulse_d    = |hit_v;
    escape_pulse_d = |exp_v;
    spawn_pulse_d  = |spawn_v;
  end

  // top-level state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ic_q           <= '0;
      hit_pulse_q    <= 1'b0;
      escape_pulse_q <= 1'b0;
      spawn_pulse_q  <= 1'b0;
      hit_count_q    <= '0;
      escape_count_q <= '0;
    end else begin
      ic_q           <= ic_d;
      hit_pulse_q    <= hit_pulse_d;
      escape_pulse_q <= escape_pulse_d;
      spawn_pulse_q  <= spawn_pulse_d;
      hit_count_q    <= hit_count_d;
      escape_count_q <= escape_count_d;
    end
  end

  assign hit_pulse    = hit_pulse_q;
  assign escape_pulse = escape_pulse_q;
  assign spawn_pulse  = spawn_pulse_q;
  assign hit_count    = hit_count_q;
  assign escape_count = escape_count_q;
endmodule

// File: tb/tb_mole_field.sv
// tb_mole_field: randomized scoreboard bench against a behavioural mole-field model
module tb_mole_field;
  import mole_field_pkg::*;
  localparam int NS = 5;
  localparam int NH = 9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] life_span = '0, gen_interval = '0, rand_in = '0;
  logic [4:0]  kill_list = '0;
  logic [19:0] moles_a, moles_b;
  logic        hp_a, ep_a, sp_a, hp_b, ep_b, sp_b;
  logic [15:0] hc_a, ec_a;
  logic [1:0]  hc_b, ec_b;

  always #5 clk = ~clk;

  mole_field dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .life_span(life_span),
    .gen_interval(gen_interval), .kill_list(kill_list), .rand_in(rand_in),
    .moles(moles_a), .hit_pulse(hp_a), .escape_pulse(ep_a), .spawn_pulse(sp_a),
    .hit_count(hc_a), .escape_count(ec_a)
  );

  mole_field #(.STAT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .life_span(life_span),
    .gen_interval(gen_interval), .kill_list(kill_list), .rand_in(rand_in),
    .moles(moles_b), .hit_pulse(hp_b), .escape_pulse(ep_b), .spawn_pulse(sp_b),
    .hit_count(hc_b), .escape_count(ec_b)
  );

  typedef struct packed {
    logic [19:0] moles;
    logic        hp, ep, sp;
    logic [15:0] hc, ec;
    logic [1:0]  hc2, ec2;
  } exp_t;

  exp_t q[$];
  int compared = 0, mismatched = 0;

  int          m_code[NS];
  bit [31:0]   m_age[NS];
  bit [31:0]   m_ic;
  int          m_hits, m_escs;
  bit          m_hp, m_ep, m_sp;
  bit [31:0]   ls_n, gi_n;

  function automatic void m_reset();
    for (int i = 0; i < NS; i++) begin
      m_code[i] = -1;
      m_age[i]  = 0;
    end
    m_ic = 0; m_hits = 0; m_escs = 0;
    m_hp = 0; m_ep = 0; m_sp = 0;
  endfunction

  function automatic void m_step(bit en, bit [4:0] kl, bit [31:0] ls, bit [31:0] gi, bit [31:0] rnd);
    int  old[NS];
    int  free_slot, start, c, pick, h, e;
    bit  attempt, taken;
    m_hp = 0; m_ep = 0; m_sp = 0;
    if (!en) return;
    old = m_code;
    attempt = (m_ic == gi);
    m_ic = attempt ? 0 : m_ic + 1;
    free_slot = -1;
    for (int i = 0; i < NS; i++) if (old[i] < 0 && free_slot < 0) free_slot = i;
    start = int'(rnd % NH);
    pick = -1;
    for (int k = 0; k < NH; k++) begin
      c = (start + k) % NH;
      taken = 0;
      for (int i = 0; i < NS; i++) if (old[i] == c) taken = 1;
      if (!taken && pick < 0) pick = c;
    end
    h = 0; e = 0;
    for (int i = 0; i < NS; i++) begin
      if (old[i] >= 0) begin
        if (kl[i]) begin h++; m_code[i] = -1; m_age[i] = 0; end
        else if (m_age[i] == ls) begin e++; m_code[i] = -1; m_age[i] = 0; end
        else m_age[i]++;
      end
    end
    if (attempt && free_slot >= 0) begin
      m_code[free_slot] = pick;
      m_age[free_slot]  = 0;
      m_sp = 1;
    end
    m_hits += h; m_escs += e;
    m_hp = h > 0; m_ep = e > 0;
  endfunction

  function automatic exp_t m_exp();
    exp_t x;
    for (int i = 0; i < NS; i++) x.moles[i*4 +: 4] = (m_code[i] < 0) ? 4'hF : 4'(m_code[i]);
    x.hp = m_hp; x.ep = m_ep; x.sp = m_sp;
    x.hc  = (m_hits > 65535) ? 16'hFFFF : 16'(m_hits);
    x.ec  = (m_escs > 65535) ? 16'hFFFF : 16'(m_escs);
    x.hc2 = (m_hits > 3) ? 2'd3 : 2'(m_hits);
    x.ec2 = (m_escs > 3) ? 2'd3 : 2'(m_escs);
    return x;
  endfunction

  task automatic cyc(bit rst, bit en, bit [4:0] kl, bit [31:0] rnd);
    @(negedge clk);
    rst_n = !rst; enable = en; kill_list = kl; rand_in = rnd;
    life_span = ls_n; gen_interval = gi_n;
    if (rst) m_reset();
    else m_step(en, kl, ls_n, gi_n, rnd);
    q.push_back(m_exp());
  endtask

  always @(posedge clk) begin : monitor
    exp_t e, g;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      g = {moles_a, hp_a, ep_a, sp_a, hc_a, ec_a, hc_b, ec_b};
      compared++;
      if (g !== e || moles_b !== e.moles || {hp_b, ep_b, sp_b} !== {e.hp, e.ep, e.sp}) begin
        mismatched++;
        $display("FAIL cycle_check t=%0t got moles=%h/%h p=%b%b%b/%b%b%b hc=%0d ec=%0d hc2=%0d ec2=%0d exp moles=%h p=%b%b%b hc=%0d ec=%0d hc2=%0d ec2=%0d",
                 $time, moles_a, moles_b, hp_a, ep_a, sp_a, hp_b, ep_b, sp_b, hc_a, ec_a, hc_b, ec_b,
                 e.moles, e.hp, e.ep, e.sp, e.hc, e.ec, e.hc2, e.ec2);
      end
    end
  end

  initial begin
    hole_t h0;
    bit [4:0] kl;
    m_reset();
    ls_n = 10; gi_n = 3;
    repeat (2) cyc(1, 0, 0, 0);
    repeat (14) cyc(0, 1, 0, 0);
    ls_n = 5; gi_n = 2;
    cyc(1, 0, 0, 0);
    repeat (30) cyc(0, 1, 0, $urandom);
    ls_n = 50; gi_n = 0;
    cyc(1, 0, 0, 0);
    repeat (12) cyc(0, 1, 0, $urandom);
    ls_n = 3; gi_n = 0;
    cyc(1, 0, 0, 0);
    for (int n = 0; n < 20; n++) begin
      kl = (m_code[0] >= 0 && m_age[0] == ls_n) ? 5'b00001 : 5'b00000;
      cyc(0, 1, kl, $urandom);
    end
    ls_n = 30; gi_n = 1;
    cyc(1, 0, 0, 0);
    repeat (8) cyc(0, 1, 0, $urandom);
    repeat (20) cyc(0, 0, 5'($urandom) | 5'b00001, $urandom);
    repeat (8) cyc(0, 1, 0, $urandom);
    ls_n = 100; gi_n = 0;
    repeat (10) cyc(0, 1, 5'b11111, $urandom);
    repeat (6) cyc(0, 1, 0, $urandom);
    repeat (2) cyc(1, 1, 5'b11111, $urandom);
    for (int n = 0; n < 800; n++) begin
      if (n % 100 == 0) begin
        ls_n = $urandom_range(0, 12);
        gi_n = $urandom_range(0, 4);
        cyc(1, 0, 0, 0);
      end else begin
        kl = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b00000;
        cyc(0, $urandom_range(0, 9) != 0, kl, $urandom);
      end
    end
    repeat (3) @(negedge clk);
    h0 = moles_a[3:0];
    if (q.size() != 0 || compared == 0) begin
      mismatched++;
      $display("FAIL drain got pending=%0d compared=%0d slot0=%h exp pending=0", q.size(), compared, h0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
